// File: rtl/mem_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mem_fifo
// Purpose  : Parametrised single-clock FIFO with registered read data,
//            occupancy count, full/empty and almost-full/almost-empty flags,
//            synchronous clear and protection against writes when full and
//            reads when empty.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        data word width in bits
//   DEPTH_E      log2 of the number of entries (DEPTH = 2**DEPTH_E)
//   AF_LEVEL     ALMOST_FULL asserts when COUNT >= AF_LEVEL
//   AE_LEVEL     ALMOST_EMPTY asserts when COUNT <= AE_LEVEL
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   CLR          synchronous clear (priority over READ/WRITE)
//   WRITE / D    write request and write data
//   READ         read request
//   Q / Q_VALID  registered read data and one-cycle "Q updated" pulse
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY   decodes of COUNT
//   COUNT        occupancy 0..DEPTH
//   OVF / UDF    sticky overflow / underflow flags
// Build option
//   MEM_FIFO_ERR_EN  when defined, OVF/UDF are live sticky error flags;
//                    otherwise they are tied to 0 and no error logic exists.
// ============================================================================
module mem_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH_E  = 6,
    parameter int AF_LEVEL = 2**DEPTH_E - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CLR,
    input  logic               WRITE,
    input  logic [WIDTH-1:0]   D,
    input  logic               READ,
    output logic [WIDTH-1:0]   Q,
    output logic               Q_VALID,
    output logic               FULL,
    output logic               EMPTY,
    output logic               ALMOST_FULL,
    output logic               ALMOST_EMPTY,
    output logic [DEPTH_E:0]   COUNT,
    output logic               OVF,
    output logic               UDF
);

    localparam int               c_DEPTH    = 2**DEPTH_E;
    // Count value meaning "completely full": only the MSB set.
    localparam logic [DEPTH_E:0] c_FULL_CNT = {1'b1, {DEPTH_E{1'b0}}};
    localparam logic [DEPTH_E:0] c_ONE      = {{DEPTH_E{1'b0}}, 1'b1};
    // Thresholds are compared one bit wider than COUNT so that a level of
    // DEPTH (or anything up to 2*DEPTH-1) still compares correctly.
    localparam logic [DEPTH_E+1:0] c_AF     = AF_LEVEL[DEPTH_E+1:0];
    localparam logic [DEPTH_E+1:0] c_AE     = AE_LEVEL[DEPTH_E+1:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [DEPTH_E:0] r_wptr;
    logic [DEPTH_E:0] r_rptr;
    logic [DEPTH_E:0] r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;

    // ------------------------------------------------------------------
    // Status decodes and acceptance
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_mem_we;

    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);

    // A read is only ever served from stored data: no write-to-read bypass.
    assign w_rd_acc = READ & ~w_empty;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign w_wr_acc = WRITE & (~w_full | w_rd_acc);
    // Clear wins over a concurrent write, so the word must not land in RAM.
    assign w_mem_we = w_wr_acc & ~CLR;

    // ------------------------------------------------------------------
    // Storage array: no reset, contents survive RST and CLR.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[r_wptr[DEPTH_E-1:0]] <= D;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and read data
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else if (CLR) begin
            // Q deliberately keeps its last value across a clear.
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_q_valid <= w_rd_acc;

            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_ONE;
            end

            if (w_rd_acc) begin
                r_q    <= r_mem[r_rptr[DEPTH_E-1:0]];
                r_rptr <= r_rptr + c_ONE;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional sticky error flags
    // ------------------------------------------------------------------
`ifdef MEM_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (CLR) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (WRITE & ~w_wr_acc) begin
                r_ovf <= 1'b1;
            end
            if (READ & w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign OVF = r_ovf;
    assign UDF = r_udf;
`else
    assign OVF = 1'b0;
    assign UDF = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Q            = r_q;
    assign Q_VALID      = r_q_valid;
    assign COUNT        = r_count;
    assign FULL         = w_full;
    assign EMPTY        = w_empty;
    assign ALMOST_FULL  = ({1'b0, r_count} >= c_AF);
    assign ALMOST_EMPTY = ({1'b0, r_count} <= c_AE);

    // ------------------------------------------------------------------
    // Invariants: the pointer distance always equals the stored count
    // (this is what the extra pointer MSB is for), and COUNT never
    // exceeds DEPTH.
    // ------------------------------------------------------------------
    a_ptr_count : assert property (@(posedge CLK) disable iff (RST)
        (r_wptr - r_rptr) == r_count);
    a_count_max : assert property (@(posedge CLK) disable iff (RST)
        r_count <= c_FULL_CNT);

endmodule
`default_nettype wire
